// File: rtl/mem_io_responder.sv
// Memory-bus responder: internal RAM below IO_BASE plus output FIFO, input holding register
// and status register mapped at IO_BASE..IO_BASE+2.
module mem_io_responder #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned OUT_DEPTH = 4,
   parameter int unsigned IO_BASE   = 'hF0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rw,
   input  logic              req,
   output logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned PtrW = $clog2(OUT_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [ADDR_W-1:0] AddrOut  = ADDR_W'(IO_BASE);
   localparam logic [ADDR_W-1:0] AddrIn   = ADDR_W'(IO_BASE + 1);
   localparam logic [ADDR_W-1:0] AddrStat = ADDR_W'(IO_BASE + 2);

   logic [DATA_W-1:0] ram [IO_BASE];
   logic [DATA_W-1:0] fifo_q [OUT_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   cnt_q;
   logic              in_full_q;
   logic [DATA_W-1:0] in_data_q;
   logic              ovf_q, unf_q;

   logic              is_ram, wr, out_full, out_empty;
   logic              out_pop, out_push_req, out_push, ovf_set;
   logic              in_pop_req, in_accept, stat_clr;
   logic [DATA_W-1:0] status;

   assign is_ram       = addr < AddrOut;
   assign wr           = req & rw;
   assign out_full     = cnt_q == CntW'(OUT_DEPTH);
   assign out_empty    = cnt_q == '0;
   assign out_pop      = out_valid & out_ready;
   assign out_push_req = wr & (addr == AddrOut);
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign out_push     = out_push_req & (~out_full | out_pop);
   assign ovf_set      = out_push_req & out_full & ~out_pop;
   assign in_pop_req   = req & ~rw & (addr == AddrIn);
   assign in_accept    = in_valid & in_ready;
   assign stat_clr     = wr & (addr == AddrStat);

   assign status    = {{(DATA_W - 5){1'b0}}, unf_q, ovf_q, out_empty, out_full, in_full_q};
   assign in_ready  = clr & ~in_full_q;
   assign out_valid = ~out_empty;
   assign out_data  = out_empty ? '0 : fifo_q[rd_ptr_q];

   always_comb begin
      rdata = '0;
      if (is_ram) begin
         rdata = ram[addr];
      end else if (addr == AddrIn) begin
         rdata = in_full_q ? in_data_q : '0;
      end else if (addr == AddrStat) begin
         rdata = status;
      end
   end

   always_ff @(posedge clk) begin
      if (wr & is_ram) begin
         ram[addr] <= wdata;
      end
      if (out_push) begin
         fifo_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         in_full_q <= 1'b0;
         in_data_q <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         if (out_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (out_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (out_push & ~out_pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (out_pop & ~out_push) begin
            cnt_q <= cnt_q - 1'b1;
         end

         // Accept needs empty and pop needs full, so the two never coincide.
         if (in_accept) begin
            in_full_q <= 1'b1;
            in_data_q <= in_data;
         end else if (in_pop_req & in_full_q) begin
            in_full_q <= 1'b0;
            in_data_q <= '0;
         end

         if (stat_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            if (ovf_set) ovf_q <= 1'b1;
            if (in_pop_req & ~in_full_q) unf_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus a randomized run against a queue model.
module tb_mem_io_responder;

   localparam int          Depth = 4;
   localparam logic [7:0]  Iob   = 8'hF0;

   logic       clk = 1'b0;
   logic       clr;
   logic [7:0] addr, wdata, rdata, in_data, out_data;
   logic       rw, req, in_valid, in_ready, out_valid, out_ready;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [7:0] m_q[$];
   logic [7:0] m_ram [240];
   bit         m_known [240];
   bit         m_hfull;
   logic [7:0] m_hval;
   bit         m_ovf, m_unf;

   mem_io_responder #(
      .DATA_W(8), .ADDR_W(8), .OUT_DEPTH(Depth), .IO_BASE(32'hF0)
   ) dut (
      .clk(clk), .clr(clr), .addr(addr), .wdata(wdata), .rw(rw), .req(req), .rdata(rdata),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] m_status();
      return {3'b000, m_unf, m_ovf, m_q.size() == 0, m_q.size() == Depth, m_hfull};
   endfunction

   function automatic logic [7:0] m_rdata(input logic [7:0] a);
      if (a < Iob) return m_ram[a];
      if (a == 8'hF1) return m_hfull ? m_hval : 8'h00;
      if (a == 8'hF2) return m_status();
      return 8'h00;
   endfunction

   task automatic bus(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
      req = r; rw = w; addr = a; wdata = d;
      #1;
   endtask

   // Advance one clock edge, updating the model from the inputs currently applied.
   task automatic tick();
      bit pop, full, acc;
      pop  = (m_q.size() != 0) && out_ready;
      full = m_q.size() == Depth;
      acc  = in_valid && !m_hfull && clr;
      @(posedge clk);
      if (req && rw && addr < Iob) begin
         m_ram[addr] = wdata;
         m_known[addr] = 1'b1;
      end
      if (!clr) begin
         m_q.delete();
         m_hfull = 0; m_hval = 0; m_ovf = 0; m_unf = 0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (req && rw && addr == Iob) begin
            if (!full || pop) m_q.push_back(wdata);
            else m_ovf = 1;
         end
         if (req && !rw && addr == 8'hF1) begin
            if (m_hfull) begin m_hfull = 0; m_hval = 0; end
            else m_unf = 1;
         end else if (acc) begin
            m_hfull = 1; m_hval = in_data;
         end
         if (req && rw && addr == 8'hF2) begin m_ovf = 0; m_unf = 0; end
      end
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b0; out_ready = 0; in_valid = 0; in_data = 0;
      bus(0, 0, 8'hF2, 0);
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      tick(); tick();
      tests++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         fails++; $display("FAIL reset_out got v=%b d=%h want v=0 d=00", out_valid, out_data);
      end
      clr = 1'b1; #1;
      tests++;
      if (rdata !== 8'h04 || in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_status got %h rdy=%b want 04 rdy=1", rdata, in_ready);
      end
   endtask

   task automatic test_ram();
      bus(1, 1, 8'h10, 8'h5A); tick();
      bus(0, 0, 8'h10, 8'h00);
      tests++;
      if (rdata !== 8'h5A) begin fails++; $display("FAIL ram_read got %h want 5a", rdata); end
      bus(0, 0, 8'hF0, 8'h00);
      tests++;
      if (rdata !== 8'h00) begin fails++; $display("FAIL io_out_read got %h want 00", rdata); end
      bus(0, 1, 8'h11, 8'hEE); tick();
      bus(0, 0, 8'h11, 8'h00);
      tests++;
      if (m_known[8'h11] && rdata !== m_ram[8'h11]) begin
         fails++; $display("FAIL ram_noreq_write got %h want %h", rdata, m_ram[8'h11]);
      end
   endtask

   task automatic test_out_fifo();
      logic [7:0] exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      out_ready = 0;
      foreach (exp[i]) begin bus(1, 1, Iob, exp[i]); tick(); end
      bus(0, 0, 8'hF2, 0);
      tests++;
      if (rdata !== 8'h02) begin fails++; $display("FAIL fifo_full_status got %h want 02", rdata); end
      bus(1, 1, Iob, 8'h55); tick();
      bus(0, 0, 8'hF2, 0);
      tests++;
      if (rdata !== 8'h0A) begin fails++; $display("FAIL fifo_ovf_status got %h want 0a", rdata); end
      out_ready = 1;
      foreach (exp[i]) begin
         #1;
         tests++;
         if (out_valid !== 1'b1 || out_data !== exp[i]) begin
            fails++; $display("FAIL fifo_drain%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp[i]);
         end
         tick();
      end
      out_ready = 0; #1;
      tests++;
      if (rdata !== 8'h0C || out_valid !== 1'b0) begin
         fails++; $display("FAIL fifo_empty_status got %h v=%b want 0c v=0", rdata, out_valid);
      end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] exp[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h99};
      bus(1, 1, 8'hF2, 0); tick();
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin bus(1, 1, Iob, exp[i]); tick(); end
      out_ready = 1; bus(1, 1, Iob, exp[4]); tick();
      out_ready = 0; bus(0, 0, 8'hF2, 0);
      tests++;
      if (rdata !== 8'h02) begin fails++; $display("FAIL pushpop_full_status got %h want 02", rdata); end
      out_ready = 1;
      for (int i = 1; i < 5; i++) begin
         #1;
         tests++;
         if (out_data !== exp[i] || out_valid !== 1'b1) begin
            fails++; $display("FAIL pushpop_order%0d got %h want %h", i, out_data, exp[i]);
         end
         tick();
      end
      out_ready = 0;
   endtask

   task automatic test_input();
      bus(0, 0, 8'h00, 0);
      in_data = 8'hA7; in_valid = 1; #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL in_ready_idle got %b want 1", in_ready); end
      tick(); in_valid = 0; in_data = 8'h00;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL in_ready_full got %b want 0", in_ready); end
      bus(1, 0, 8'hF1, 0);
      tests++;
      if (rdata !== 8'hA7) begin fails++; $display("FAIL in_pop_data got %h want a7", rdata); end
      tick(); bus(0, 0, 8'h00, 0);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL in_ready_after_pop got %b want 1", in_ready); end
      bus(1, 0, 8'hF1, 0);
      tests++;
      if (rdata !== 8'h00) begin fails++; $display("FAIL in_empty_read got %h want 00", rdata); end
      tick(); bus(0, 0, 8'hF2, 0);
      tests++;
      if (rdata[4] !== 1'b1) begin fails++; $display("FAIL in_unf got %b want 1", rdata[4]); end
   endtask

   task automatic test_status_clear();
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin bus(1, 1, Iob, 8'(8'hC0 + i)); tick(); end
      bus(0, 0, 8'hF2, 0);
      tests++;
      if (rdata !== 8'h1A) begin fails++; $display("FAIL stat_sticky got %h want 1a", rdata); end
      bus(1, 1, 8'hF2, 8'hFF); tick();
      bus(0, 0, 8'hF2, 0);
      tests++;
      if (rdata !== 8'h02) begin fails++; $display("FAIL stat_clear got %h want 02", rdata); end
      out_ready = 1;
      for (int i = 0; i < 4; i++) tick();
      out_ready = 0;
   endtask

   task automatic test_reset_mid();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin bus(1, 1, Iob, 8'(8'h70 + i)); tick(); end
      in_data = 8'h3C; in_valid = 1; bus(0, 0, 8'hF2, 0); tick(); in_valid = 0;
      clr = 0; #1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_reset_in_ready got %b want 0", in_ready); end
      tick(); clr = 1; #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || rdata !== 8'h04) begin
         fails++;
         $display("FAIL mid_reset_release got v=%b rdy=%b st=%h want 0 1 04", out_valid, in_ready, rdata);
      end
   endtask

   task automatic test_random();
      logic [7:0] pick[8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
      logic [7:0] exp;
      for (int n = 0; n < 400; n++) begin
         in_data   = 8'($urandom);
         in_valid  = $urandom_range(0, 1) == 1;
         out_ready = $urandom_range(0, 2) == 0;
         bus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8'h04, 8'hFF)) : pick[$urandom_range(0, 7)],
             8'($urandom));
         exp = m_rdata(addr);
         if (addr >= Iob || m_known[addr]) begin
            tests++;
            if (rdata !== exp) begin
               fails++; $display("FAIL rand_rdata@%h cyc %0d got %h want %h", addr, n, rdata, exp);
            end
         end
         tests++;
         if (out_valid !== (m_q.size() != 0) || out_data !== (m_q.size() != 0 ? m_q[0] : 8'h00)
             || in_ready !== !m_hfull) begin
            fails++;
            $display("FAIL rand_ports cyc %0d got v=%b d=%h rdy=%b want v=%b d=%h rdy=%b", n,
                     out_valid, out_data, in_ready, m_q.size() != 0,
                     m_q.size() != 0 ? m_q[0] : 8'h00, !m_hfull);
         end
         tick();
      end
   endtask

   initial begin
      clr = 0; req = 0; rw = 0; addr = 0; wdata = 0;
      in_data = 0; in_valid = 0; out_ready = 0;
      @(negedge clk);
      test_reset();
      test_ram();
      test_out_fifo();
      test_push_pop_full();
      test_input();
      test_status_clear();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
